fft_frame_ctrl: RTL

// Frame sequencer wrapped around the in-place radix-2 fft core.
// - Accepts a real sample stream (valid/ready) and drives the core's load/start.
// - Captures the N output bins into a local bin buffer as the core emits them.
// - Streams the bins out (valid/ready/last).
// - Overlaps loading of frame k+1 with unloading of frame k.

---
 rtl/fft_frame_ctrl.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: frame sequencer around an in-place radix-2 FFT core.
//   Accepts a real sample stream, feeds it to the core (load/start), captures the N output
//   bins into a local buffer while the core emits them, and streams the bins out in natural
//   order. Loading of the next frame overlaps unloading of the current one.
// Ports:
//   i_clk, i_reset_n              clock, asynchronous active-low reset
//   i_s_valid/o_s_ready/i_s_data  sample input stream
//   o_m_valid/i_m_ready/o_m_data  bin output stream ({re,im}), with o_m_index and o_m_last
//   i_abort                       synchronous abort of the frame in progress
//   o_err                         sticky compute timeout flag
//   o_busy                        core sequencer is not idle in LOAD
//   o_fft_reset/load/start/rd     core controls and sample data
//   i_fft_wd, i_fft_done          core bin data and done strobe
// Configuration macro:
//   FFT_CTRL_PRESCALE_EN  when defined, samples are arithmetically shifted right by N_2 before
//                         loading to leave bit-growth headroom; otherwise passed unmodified.
module fft_frame_ctrl #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned N_2     = 5,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_s_valid,
  output logic               o_s_ready,
  input  logic [WIDTH-1:0]   i_s_data,
  output logic               o_m_valid,
  input  logic               i_m_ready,
  output logic [2*WIDTH-1:0] o_m_data,
  output logic [N_2-1:0]     o_m_index,
  output logic               o_m_last,
  input  logic               i_abort,
  output logic               o_err,
  output logic               o_busy,
  output logic               o_fft_reset,
  output logic               o_fft_load,
  output logic               o_fft_start,
  output logic [WIDTH-1:0]   o_fft_rd,
  input  logic [2*WIDTH-1:0] i_fft_wd,
  input  logic               i_fft_done
);

  localparam int unsigned      N       = 1 << N_2;
  localparam int unsigned      TW      = $clog2(TIMEOUT + 1);
  localparam logic [N_2-1:0]   LastIdx = '1;
  localparam logic [TW-1:0]    TmoLast = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {StClr, StLoad, StWait, StStart, StCompute, StCapture} core_state_e;
  typedef enum logic {StEmpty, StFull} out_state_e;

  core_state_e        r_core_state, w_core_nxt;
  out_state_e         r_out_state, w_out_nxt;
  logic [N_2-1:0]     r_cnt, w_cnt_nxt;
  logic [N_2-1:0]     r_cap, w_cap_nxt;
  logic [N_2-1:0]     r_idx, w_idx_nxt;
  logic [TW-1:0]      r_tmo, w_tmo_nxt;
  logic               r_err, w_err_nxt;
  logic               r_fft_load, w_load_nxt;
  logic [WIDTH-1:0]   r_fft_rd, w_rd_nxt;
  logic [2*WIDTH-1:0] r_buf [N];
  logic               w_buf_we;
  logic [N_2-1:0]     w_buf_idx;
  logic               w_accept;
  logic [WIDTH-1:0]   w_rd_in;

`ifdef FFT_CTRL_PRESCALE_EN
  assign w_rd_in = $signed(i_s_data) >>> N_2;
`else
  assign w_rd_in = i_s_data;
`endif

  // Abort blocks acceptance so a sample offered in the abort cycle is never taken and lost.
  assign o_s_ready = (r_core_state == StLoad) & ~i_abort;
  assign w_accept  = o_s_ready & i_s_valid;

  always_comb begin
    w_core_nxt = r_core_state;
    w_out_nxt  = r_out_state;
    w_cnt_nxt  = r_cnt;
    w_cap_nxt  = r_cap;
    w_idx_nxt  = r_idx;
    w_tmo_nxt  = r_tmo;
    w_err_nxt  = r_err;
    w_load_nxt = 1'b0;
    w_rd_nxt   = r_fft_rd;
    w_buf_we   = 1'b0;
    w_buf_idx  = r_cap;

    if (w_accept) begin
      w_load_nxt = 1'b1;
      w_rd_nxt   = w_rd_in;
    end

    unique case (r_core_state)
      StClr: w_core_nxt = StLoad;
      StLoad: begin
        if (w_accept) begin
          w_cnt_nxt = r_cnt + 1'b1;
          if (r_cnt == LastIdx) w_core_nxt = StWait;
        end
      end
      // The Nth load pulse goes out during this cycle; start only once the buffer is drained.
      StWait: if (r_out_state == StEmpty) w_core_nxt = StStart;
      StStart: begin
        w_tmo_nxt  = TW'(1);
        w_core_nxt = StCompute;
      end
      StCompute: begin
        if (i_fft_done) begin
          // First done cycle already carries bin 0.
          w_buf_we   = 1'b1;
          w_buf_idx  = '0;
          w_cap_nxt  = N_2'(1);
          w_core_nxt = StCapture;
        end else if (r_tmo == TmoLast) begin
          w_err_nxt  = 1'b1;
          w_core_nxt = StClr;
        end else begin
          w_tmo_nxt = r_tmo + 1'b1;
        end
      end
      StCapture: begin
        w_buf_we  = 1'b1;
        w_cap_nxt = r_cap + 1'b1;
        if (r_cap == LastIdx) begin
          w_out_nxt  = StFull;
          w_core_nxt = StClr;
        end
      end
      default: w_core_nxt = StClr;
    endcase

    if (r_out_state == StFull && i_m_ready) begin
      w_idx_nxt = r_idx + 1'b1;
      if (r_idx == LastIdx) w_out_nxt = StEmpty;
    end

    if (i_abort) begin
      w_core_nxt = StClr;
      w_out_nxt  = StEmpty;
      w_cnt_nxt  = '0;
      w_cap_nxt  = '0;
      w_idx_nxt  = '0;
      w_err_nxt  = r_err;
      w_load_nxt = 1'b0;
      w_buf_we   = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_core_state <= StClr;
      r_out_state  <= StEmpty;
      r_cnt        <= '0;
      r_cap        <= '0;
      r_idx        <= '0;
      r_tmo        <= '0;
      r_err        <= 1'b0;
      r_fft_load   <= 1'b0;
      r_fft_rd     <= '0;
    end else begin
      r_core_state <= w_core_nxt;
      r_out_state  <= w_out_nxt;
      r_cnt        <= w_cnt_nxt;
      r_cap        <= w_cap_nxt;
      r_idx        <= w_idx_nxt;
      r_tmo        <= w_tmo_nxt;
      r_err        <= w_err_nxt;
      r_fft_load   <= w_load_nxt;
      r_fft_rd     <= w_rd_nxt;
    end
  end

  // Bin buffer holds data only; its contents are meaningless until a capture completes.
  always_ff @(posedge i_clk) begin
    if (w_buf_we) r_buf[w_buf_idx] <= i_fft_wd;
  end

  assign o_m_valid   = (r_out_state == StFull);
  assign o_m_data    = o_m_valid ? r_buf[r_idx] : '0;
  assign o_m_index   = r_idx;
  assign o_m_last    = o_m_valid & (r_idx == LastIdx);
  assign o_err       = r_err;
  assign o_fft_reset = (r_core_state == StClr);
  assign o_fft_load  = r_fft_load;
  assign o_fft_start = (r_core_state == StStart);
  assign o_fft_rd    = r_fft_rd;
  // The one-cycle CLR counts as idle so busy reads 0 straight out of reset.
  assign o_busy      = !(((r_core_state == StLoad) || (r_core_state == StClr)) && (r_cnt == '0));

endmodule
